// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifu_fetch_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned INST_BYTES = 4;

  localparam logic [XLEN-1:0] INST_NOP       = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_ADDR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_STEP      = XLEN'(INST_BYTES);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] addr;
  } fetch_buf_t;

  // Clear the byte-offset bits so every fetch is word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/ifu_pc.sv
// Program counter: reset load, aligned redirect, and +4 on accepted fetch.
module ifu_pc
  import ifu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_flag,
  input  logic [XLEN-1:0] jump_addr,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);

  // A redirect always wins over the increment on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= word_align(RESET_ADDR);
    end else if (jump_flag) begin
      pc <= word_align(jump_addr);
    end else if (inc) begin
      pc <= pc + INST_STEP;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: one outstanding bus transaction, single-entry output
// buffer toward IF/ID, redirect handling with stale-response discard.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = RESET_ADDR_DEF,
  parameter logic [XLEN-1:0] NOP_INST   = INST_NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_flag_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            hold_flag_i,
  output logic            ibus_req_o,
  output logic [XLEN-1:0] ibus_addr_o,
  input  logic            ibus_gnt_i,
  input  logic            ibus_rvalid_i,
  input  logic [XLEN-1:0] ibus_rdata_i,
  output logic            ibus_rready_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic            inst_valid_o
);

  fetch_state_e    state_q, state_d;
  logic            discard_q, discard_d;
  logic            buf_valid_q, buf_valid_d;
  fetch_buf_t      buf_q, buf_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] pc;
  logic            pc_inc;

  logic grant_c;
  logic rsp_c;
  logic consume_c;

  ifu_pc #(
    .RESET_ADDR(RESET_ADDR)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .jump_flag (jump_flag_i),
    .jump_addr (jump_addr_i),
    .inc       (pc_inc),
    .pc        (pc)
  );

  // A held, full buffer back-pressures the response channel.
  assign ibus_rready_o = !buf_valid_q || !hold_flag_i;

  assign grant_c   = (state_q == S_REQ) && ibus_gnt_i;
  assign rsp_c     = (state_q == S_WAIT) && ibus_rvalid_i && ibus_rready_o;
  assign consume_c = buf_valid_q && !hold_flag_i && !jump_flag_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      discard_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
      req_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
      req_addr_q  <= req_addr_d;
    end
  end

  // Next-state, buffer update and bus request drive.
  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    req_addr_d  = req_addr_q;
    pc_inc      = 1'b0;
    ibus_req_o  = 1'b0;
    ibus_addr_o = pc;

    case (state_q)
      S_REQ: begin
        ibus_req_o = 1'b1;
        if (grant_c) begin
          state_d    = S_WAIT;
          req_addr_d = pc;
          if (jump_flag_i) begin
            discard_d = 1'b1;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (rsp_c) begin
          state_d   = S_REQ;
          discard_d = 1'b0;
        end else if (jump_flag_i) begin
          discard_d = 1'b1;
        end
      end
    endcase

    if (consume_c) begin
      buf_valid_d = 1'b0;
    end

    // A response racing a redirect, or one flagged stale, is dropped.
    if (rsp_c && !discard_q && !jump_flag_i) begin
      buf_d.inst  = ibus_rdata_i;
      buf_d.addr  = req_addr_q;
      buf_valid_d = 1'b1;
    end

    if (jump_flag_i) begin
      buf_valid_d = 1'b0;
    end
  end

  assign inst_o       = buf_valid_q ? buf_q.inst : NOP_INST;
  assign inst_addr_o  = buf_valid_q ? buf_q.addr : '0;
  assign inst_valid_o = buf_valid_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized scoreboard bench for ifu_fetch with an in-bench memory agent.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        hold_flag_i = 1'b0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_rdata_i = '0;
  logic        ibus_rready_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  ifu_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .hold_flag_i   (hold_flag_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .ibus_rready_o (ibus_rready_o),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .inst_valid_o  (inst_valid_o)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int delivered   = 0;

  // Scoreboard: addresses of granted fetches that must reach IF/ID in order.
  logic [31:0] exp_q[$];
  logic [31:0] pc_m;
  int          maxd = 0;

  // Memory agent state.
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_dly = 0;

  bit          prev_rst = 1'b0;
  bit          prev_hold_keep = 1'b0;
  logic [31:0] prev_inst, prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check post-edge state, drive inputs, then model the coming edge.
  task automatic cycle(input bit r, input bit g, input bit h, input bit j, input logic [31:0] ja);
    @(negedge clk);
    if (prev_rst) begin
      chk("rst_valid", 32'(inst_valid_o), 32'd0);
      chk("rst_inst", inst_o, INST_NOP);
      chk("rst_addr", inst_addr_o, 32'h0);
      chk("rst_rready", 32'(ibus_rready_o), 32'd1);
      chk("rst_req", 32'(ibus_req_o), 32'd1);
      chk("rst_req_addr", ibus_addr_o, RESET_ADDR_DEF);
    end else if (!inst_valid_o) begin
      chk("nop_inst", inst_o, INST_NOP);
      chk("nop_addr", inst_addr_o, 32'h0);
    end
    if (prev_hold_keep) begin
      chk("hold_valid", 32'(inst_valid_o), 32'd1);
      chk("hold_inst", inst_o, prev_inst);
      chk("hold_addr", inst_addr_o, prev_addr);
    end

    rst         = r;
    ibus_gnt_i  = g;
    hold_flag_i = h;
    jump_flag_i = j;
    jump_addr_i = ja;
    if (pend && pend_dly == 0) begin
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i  = mem_word(pend_addr);
    end else begin
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = $urandom;
      if (pend && pend_dly > 0) pend_dly--;
    end
    #1;

    chk("rready", 32'(ibus_rready_o), 32'(!inst_valid_o || !h));
    prev_rst       = r;
    prev_hold_keep = !r && inst_valid_o && h && !j;
    prev_inst      = inst_o;
    prev_addr      = inst_addr_o;

    if (r) begin
      exp_q.delete();
      pc_m = RESET_ADDR_DEF;
      pend = 1'b0;
    end else begin
      if (ibus_req_o && g) begin
        chk("req_addr", ibus_addr_o, pc_m);
        chk("one_outstanding", 32'(pend), 32'd0);
        exp_q.push_back(pc_m);
        pend      = 1'b1;
        pend_addr = ibus_addr_o;
        pend_dly  = $urandom_range(0, maxd);
        pc_m      = pc_m + 32'd4;
      end
      if (ibus_rvalid_i && ibus_rready_o) pend = 1'b0;
      if (j) begin
        exp_q.delete();
        pc_m = ja & ~32'h3;
      end
    end
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0: t = 32'h0000_0100;
      1: t = 32'h0000_0203;
      2: t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: t = $urandom;
    endcase
    return t;
  endfunction

  task automatic run_phase(input int n, input int d, input int pg, input int ph, input int pj);
    maxd = d;
    for (int i = 0; i < n; i++) begin
      bit g, h, j;
      g = ($urandom_range(0, 99) < pg);
      h = ($urandom_range(0, 99) < ph);
      j = ($urandom_range(0, 99) < pj);
      cycle(1'b0, g, h, j, pick_target());
    end
  endtask

  // Monitor: every consumption by IF/ID pops and checks the oldest expected fetch.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && inst_valid_o === 1'b1 && !hold_flag_i && !jump_flag_i) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_inst: got addr %h expected none at %0t", inst_addr_o, $time);
        end else begin
          e = exp_q.pop_front();
          chk("inst_addr", inst_addr_o, e);
          chk("inst_data", inst_o, mem_word(e));
          delivered++;
        end
      end
    end
  end

  initial begin
    bit got_wait;
    pc_m = RESET_ADDR_DEF;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    // Always-grant, one-cycle response: 0x0, 0x4, 0x8 stream.
    maxd = 0;
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Hold over a full buffer with a response pending, then release.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    run_phase(400, 0, 100, 20, 5);
    run_phase(400, 3, 70, 30, 8);
    run_phase(400, 1, 50, 50, 15);
    run_phase(300, 2, 90, 10, 0);

    // Redirect near the top of the address space to exercise PC wrap.
    maxd = 0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Reset while waiting on a slow response.
    maxd = 40;
    got_wait = 1'b0;
    for (int i = 0; i < 20 && !got_wait; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      got_wait = pend && pend_dly > 2;
    end
    chk("reach_wait", 32'(got_wait), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    maxd = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    chk("progress", 32'(delivered > 100), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues word fetches on a simple request/response instruction bus, one transaction outstanding at a time.
- Buffers one returned instruction and presents it, with its address, to the IF/ID register.
- Handles jump redirects from execute and hold requests from ctrl; stale bus responses after a redirect are discarded.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.
- NOP_INST, 32'h0000_0013, instruction driven when no valid instruction is buffered (same value as `INST_NOP).

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- jump_flag_i  input  1  one-cycle redirect request from execute.
- jump_addr_i  input  32  redirect target.
- hold_flag_i  input  1  ctrl stall; the buffered instruction must not be consumed.
- ibus_req_o  output  1  fetch request valid.
- ibus_addr_o  output  32  fetch word address.
- ibus_gnt_i  input  1  request accepted when ibus_req_o && ibus_gnt_i.
- ibus_rvalid_i  input  1  response valid.
- ibus_rdata_i  input  32  response instruction word.
- ibus_rready_o  output  1  response accepted when ibus_rvalid_i && ibus_rready_o.
- inst_o  output  32  instruction to the IF/ID register.
- inst_addr_o  output  32  address of inst_o.
- inst_valid_o  output  1  inst_o holds a real fetched instruction.

Behaviour:
- Reset (rst high at a rising edge) sets:
  - pc = RESET_ADDR, state = S_REQ, buf_valid = 0, discard = 0.
  - Resulting outputs: inst_o = NOP_INST, inst_addr_o = 0, inst_valid_o = 0, ibus_rready_o = 1.
- Reset asserted mid-transaction abandons the transaction. The bus agent must also be reset; no response is expected after reset.
- State machine has two states: S_REQ and S_WAIT.
- S_REQ:
  - Drive ibus_req_o = 1 and ibus_addr_o = pc.
  - On grant: latch req_addr = pc, set pc = pc + 4 (mod 2^32, wraps silently), go to S_WAIT.
- S_WAIT:
  - ibus_req_o = 0.
  - On a response handshake:
    - If discard = 1: drop the data, clear discard.
    - Otherwise: load the buffer with {ibus_rdata_i, req_addr} and set buf_valid = 1.
    - In both cases go to S_REQ.
- ibus_rready_o = !buf_valid || !hold_flag_i. A held, full buffer back-pressures the response.
- Consumption: the buffer is consumed on any edge where buf_valid && !hold_flag_i && !jump_flag_i.
  - If a response handshake occurs on the same edge, the buffer reloads with the new word.
  - Otherwise buf_valid becomes 0.
- Outputs:
  - inst_o = buf_valid ? buf_inst : NOP_INST.
  - inst_addr_o = buf_valid ? buf_addr : 0.
  - inst_valid_o = buf_valid.
  - All three are registered-state driven, with no combinational path from ibus inputs.
- Jump (jump_flag_i = 1) takes priority over hold and over normal fetch:
  - pc = {jump_addr_i[31:2], 2'b00}; buf_valid = 0.
  - In S_REQ with a grant on the same edge: go to S_WAIT with discard = 1. pc still takes the jump target, not +4.
  - In S_REQ without a grant: stay in S_REQ; the next request uses the target.
  - In S_WAIT with a response handshake on the same edge: drop the data, go to S_REQ, discard = 0.
  - In S_WAIT without a response: stay in S_WAIT, set discard = 1.
  - A second jump while discard = 1 keeps discard = 1, and the newest target wins.
- Hold does not stop request issue; only response acceptance is throttled through rready.
- Latency:
  - Grant at edge N and response at edge N+1 or later: inst_valid_o rises after the response edge.
  - Best case is 2 cycles from request to output.
  - Peak throughput is one instruction every 2 cycles.

Decomposition:
- defines.v owns `INST_NOP, `RESET_ADDR, and the fetch state encodings S_REQ and S_WAIT.
- One natural sub-module: ifu_pc.
  - Inputs: reset, jump redirect, grant increment.
  - Output: pc.
  - Holds the PC register and the alignment masking.
- The fetch FSM, discard flag and output buffer stay in ifu_fetch.

Test Plan:
- Reset release, bus always grants, rvalid one cycle after grant.
  - Fetch addresses are 0x0, 0x4, 0x8.
  - inst_o sequence equals the memory words, with inst_addr_o 0x0, 0x4, 0x8, each valid for one cycle with NOP cycles between.
- hold_flag_i high for 5 cycles while buf_valid = 1 and a response is pending.
  - inst_o and inst_addr_o stay stable, ibus_rready_o = 0, and the response stalls.
  - After hold drops, the next word is delivered with no loss or duplication.
- Jump to 0x100 while in S_WAIT for address 0x8.
  - The 0x8 response is discarded.
  - The next request address is 0x100, and the next valid inst_addr_o is 0x100.
- Jump to 0x203 in the same cycle as a grant for 0x10.
  - The 0x10 response is dropped and the next request address is 0x200.
  - A simultaneous hold does not block the redirect.
- Jump in the same cycle as the response handshake.
  - The data is dropped, and the next request to the target issues on the following cycle.
- pc = 0xFFFF_FFFC fetched: the next request address is 0x0000_0000. Then assert rst mid-S_WAIT: all outputs return to their reset values on the next edge.
